// File: rtl/pipe_hazard_unit.sv
// Hazard, forwarding and sequencing controller for the RV64I pipeline.
// Shadows every instruction through E, M1..M<MEM_LAT> and W. From that it
// derives load-use stalls, branch flushes, bypass selects, memory
// back-pressure freezes and the ECALL halt/console sequencer.
//
// ECALL sequencer states:
//   state      | meaning
//   ST_RUN     | normal execution; ECALLs reaching W are serviced here
//   ST_CONSOLE | console character pending; pipeline frozen until accepted
//   ST_HALTED  | program finished or bad service; frozen until reset
module pipe_hazard_unit #(
    parameter int NUM_SRC = 2,
    parameter int MEM_LAT = 1,
    parameter int RA_W    = 5,
    parameter int XLEN    = 64,
    localparam int FWD_W  = $clog2(MEM_LAT + 2)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_d_valid,
    input  logic [NUM_SRC*RA_W-1:0]   i_d_rs,
    input  logic [NUM_SRC-1:0]        i_d_use_rs,
    input  logic [RA_W-1:0]           i_d_rd,
    input  logic                      i_d_wen,
    input  logic                      i_d_is_load,
    input  logic                      i_d_is_ecall,
    input  logic                      i_br_taken,
    input  logic                      i_dm_busy,
    input  logic [XLEN-1:0]           i_reg_a0,
    input  logic [XLEN-1:0]           i_reg_a1,
    input  logic                      i_con_ready,
    output logic                      o_stall,
    output logic                      o_flush,
    output logic                      o_freeze,
    output logic [NUM_SRC*FWD_W-1:0]  o_e_fwd_sel,
    output logic [NUM_SRC-1:0]        o_d_fwd_w,
    output logic                      o_w_wen,
    output logic [RA_W-1:0]           o_w_rd,
    output logic                      o_con_valid,
    output logic [7:0]                o_con_char,
    output logic                      o_halt,
    output logic                      o_ecall_err
);

    // Shadow slots 1..MEM_LAT are M1..M<MEM_LAT>; slot NST is W. The slot
    // index doubles as the forward-select code.
    localparam int NST = MEM_LAT + 1;

    typedef enum logic [1:0] {ST_RUN, ST_CONSOLE, ST_HALTED} state_t;

    state_t                    r_state;
    logic                      r_e_valid, r_e_wen, r_e_is_load, r_e_is_ecall;
    logic [RA_W-1:0]           r_e_rd;
    logic [NUM_SRC*RA_W-1:0]   r_e_rs;
    logic [NUM_SRC-1:0]        r_e_use_rs;
    logic                      r_p_valid    [1:NST];
    logic                      r_p_wen      [1:NST];
    logic                      r_p_is_load  [1:NST];
    logic                      r_p_is_ecall [1:NST];
    logic [RA_W-1:0]           r_p_rd       [1:NST];

    logic                      w_freeze, w_ld_hit, w_bubble, w_trigger;
    logic [NUM_SRC*FWD_W-1:0]  w_fwd_sel;
    logic [NUM_SRC-1:0]        w_d_fwd_w;
    logic                      w_unused_a1;

    function automatic logic f_match(input logic v, input logic wen,
                                     input logic [RA_W-1:0] rd,
                                     input logic [RA_W-1:0] r);
        return v & wen & (rd == r) & (r != '0);
    endfunction

    // Only the low byte of a1 carries the console character.
    assign w_unused_a1 = ^i_reg_a1[XLEN-1:8];

    assign w_freeze  = i_dm_busy | (r_state != ST_RUN);
    assign w_trigger = (r_state == ST_RUN) & r_p_valid[NST] & r_p_is_ecall[NST] & ~i_dm_busy;

    // Load-use detection against loads whose data is not yet forwardable
    always_comb begin
        w_ld_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (i_d_use_rs[i]) begin
                if (r_e_is_load && f_match(r_e_valid, r_e_wen, r_e_rd, i_d_rs[i*RA_W +: RA_W]))
                    w_ld_hit = 1'b1;
                for (int k = 1; k <= MEM_LAT - 1; k++) begin
                    if (r_p_is_load[k] && f_match(r_p_valid[k], r_p_wen[k], r_p_rd[k], i_d_rs[i*RA_W +: RA_W]))
                        w_ld_hit = 1'b1;
                end
            end
        end
    end

    // Freeze overrides everything; flush overrides stall. All quiet in reset.
    assign o_freeze = rst & w_freeze;
    assign o_flush  = rst & i_br_taken & ~w_freeze;
    assign o_stall  = rst & i_d_valid & w_ld_hit & ~i_br_taken & ~w_freeze;
    assign w_bubble = i_br_taken | (i_d_valid & w_ld_hit);

    // E-operand bypass select: scan oldest to youngest so the youngest match wins
    always_comb begin
        w_fwd_sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = NST; k >= 1; k--) begin
                if (r_e_use_rs[i] &&
                    f_match(r_p_valid[k], r_p_wen[k], r_p_rd[k], r_e_rs[i*RA_W +: RA_W]) &&
                    (!r_p_is_load[k] || k >= MEM_LAT))
                    w_fwd_sel[i*FWD_W +: FWD_W] = FWD_W'(k);
            end
        end
    end

    // D-operand bypass of the value being written back this cycle
    always_comb begin
        w_d_fwd_w = '0;
        for (int i = 0; i < NUM_SRC; i++)
            w_d_fwd_w[i] = i_d_use_rs[i] &
                           f_match(r_p_valid[NST], r_p_wen[NST], r_p_rd[NST], i_d_rs[i*RA_W +: RA_W]);
    end

    assign o_e_fwd_sel = w_fwd_sel;
    assign o_d_fwd_w   = w_d_fwd_w;
    // A frozen W entry must not write twice.
    assign o_w_wen     = rst & r_p_valid[NST] & r_p_wen[NST] & ~w_freeze;
    assign o_w_rd      = r_p_rd[NST];

    // Shadow pipeline: advance one stage per cycle unless frozen
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_e_valid    <= 1'b0;
            r_e_wen      <= 1'b0;
            r_e_is_load  <= 1'b0;
            r_e_is_ecall <= 1'b0;
            r_e_rd       <= '0;
            r_e_rs       <= '0;
            r_e_use_rs   <= '0;
            for (int k = 1; k <= NST; k++) begin
                r_p_valid[k]    <= 1'b0;
                r_p_wen[k]      <= 1'b0;
                r_p_is_load[k]  <= 1'b0;
                r_p_is_ecall[k] <= 1'b0;
                r_p_rd[k]       <= '0;
            end
        end else if (!w_freeze) begin
            r_p_valid[1]    <= r_e_valid;
            r_p_wen[1]      <= r_e_wen;
            r_p_is_load[1]  <= r_e_is_load;
            r_p_is_ecall[1] <= r_e_is_ecall;
            r_p_rd[1]       <= r_e_rd;
            for (int k = 2; k <= NST; k++) begin
                r_p_valid[k]    <= r_p_valid[k-1];
                r_p_wen[k]      <= r_p_wen[k-1];
                r_p_is_load[k]  <= r_p_is_load[k-1];
                r_p_is_ecall[k] <= r_p_is_ecall[k-1];
                r_p_rd[k]       <= r_p_rd[k-1];
            end
            // Bubbles and empty D slots enter E fully cleared so they never match.
            if (w_bubble || !i_d_valid) begin
                r_e_valid    <= 1'b0;
                r_e_wen      <= 1'b0;
                r_e_is_load  <= 1'b0;
                r_e_is_ecall <= 1'b0;
                r_e_rd       <= '0;
                r_e_rs       <= '0;
                r_e_use_rs   <= '0;
            end else begin
                r_e_valid    <= 1'b1;
                r_e_wen      <= i_d_wen;
                r_e_is_load  <= i_d_is_load;
                r_e_is_ecall <= i_d_is_ecall;
                r_e_rd       <= i_d_rd;
                r_e_rs       <= i_d_rs;
                r_e_use_rs   <= i_d_use_rs;
            end
        end
    end

    // ECALL sequencer with registered console/halt outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            o_con_valid <= 1'b0;
            o_con_char  <= '0;
            o_halt      <= 1'b0;
            o_ecall_err <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_trigger) begin
                        if (i_reg_a0 == '0) begin
                            o_halt  <= 1'b1;
                            r_state <= ST_HALTED;
                        end else if (i_reg_a0 == XLEN'(1)) begin
                            o_con_char  <= i_reg_a1[7:0];
                            o_con_valid <= 1'b1;
                            r_state     <= ST_CONSOLE;
                        end else begin
                            o_ecall_err <= 1'b1;
                            o_halt      <= 1'b1;
                            r_state     <= ST_HALTED;
                        end
                    end
                end
                ST_CONSOLE: begin
                    if (o_con_valid && i_con_ready) begin
                        o_con_valid <= 1'b0;
                        r_state     <= ST_RUN;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: one MEM_LAT=1 and one MEM_LAT=3 instance share
// the D-stage stimulus (each with its own d_valid). Expected values are queued
// as stimulus is applied and checked at the following falling edge.
module tb_pipe_hazard_unit;

    localparam int RA_W = 5;
    localparam int XLEN = 64;
    localparam int NS   = 2;

    localparam int ID_STALL1 = 0,  ID_FLUSH1 = 1,  ID_FREEZE1 = 2, ID_SEL1  = 3;
    localparam int ID_DFW1   = 4,  ID_WWEN1  = 5,  ID_WRD1    = 6, ID_CONV1 = 7;
    localparam int ID_CONC1  = 8,  ID_HALT1  = 9,  ID_ERR1    = 10;
    localparam int ID_STALL3 = 11, ID_SEL3   = 12, ID_DFW3    = 13, ID_FREEZE3 = 14;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d_valid1, d_valid3;
    logic [NS*RA_W-1:0] d_rs;
    logic [NS-1:0] d_use_rs;
    logic [RA_W-1:0] d_rd;
    logic d_wen, d_is_load, d_is_ecall, br_taken, dm_busy, con_ready;
    logic [XLEN-1:0] reg_a0, reg_a1;

    logic stall1, flush1, freeze1, wwen1, conv1, halt1, err1;
    logic [3:0] sel1;
    logic [1:0] dfw1;
    logic [RA_W-1:0] wrd1;
    logic [7:0] conc1;

    logic stall3, flush3, freeze3, wwen3, conv3, halt3, err3;
    logic [5:0] sel3;
    logic [1:0] dfw3;
    logic [RA_W-1:0] wrd3;
    logic [7:0] conc3;

    typedef struct {
        string       tag;
        int          id;
        logic [63:0] exp;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pipe_hazard_unit #(.NUM_SRC(NS), .MEM_LAT(1), .RA_W(RA_W), .XLEN(XLEN)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_d_valid(d_valid1), .i_d_rs(d_rs), .i_d_use_rs(d_use_rs), .i_d_rd(d_rd),
        .i_d_wen(d_wen), .i_d_is_load(d_is_load), .i_d_is_ecall(d_is_ecall),
        .i_br_taken(br_taken), .i_dm_busy(dm_busy), .i_reg_a0(reg_a0), .i_reg_a1(reg_a1),
        .i_con_ready(con_ready),
        .o_stall(stall1), .o_flush(flush1), .o_freeze(freeze1), .o_e_fwd_sel(sel1),
        .o_d_fwd_w(dfw1), .o_w_wen(wwen1), .o_w_rd(wrd1), .o_con_valid(conv1),
        .o_con_char(conc1), .o_halt(halt1), .o_ecall_err(err1)
    );

    pipe_hazard_unit #(.NUM_SRC(NS), .MEM_LAT(3), .RA_W(RA_W), .XLEN(XLEN)) u_dut3 (
        .clk(clk), .rst(rst),
        .i_d_valid(d_valid3), .i_d_rs(d_rs), .i_d_use_rs(d_use_rs), .i_d_rd(d_rd),
        .i_d_wen(d_wen), .i_d_is_load(d_is_load), .i_d_is_ecall(d_is_ecall),
        .i_br_taken(br_taken), .i_dm_busy(dm_busy), .i_reg_a0(reg_a0), .i_reg_a1(reg_a1),
        .i_con_ready(con_ready),
        .o_stall(stall3), .o_flush(flush3), .o_freeze(freeze3), .o_e_fwd_sel(sel3),
        .o_d_fwd_w(dfw3), .o_w_wen(wwen3), .o_w_rd(wrd3), .o_con_valid(conv3),
        .o_con_char(conc3), .o_halt(halt3), .o_ecall_err(err3)
    );

    function automatic logic [63:0] obs(input int id);
        case (id)
            ID_STALL1:  return 64'(stall1);
            ID_FLUSH1:  return 64'(flush1);
            ID_FREEZE1: return 64'(freeze1);
            ID_SEL1:    return 64'(sel1);
            ID_DFW1:    return 64'(dfw1);
            ID_WWEN1:   return 64'(wwen1);
            ID_WRD1:    return 64'(wrd1);
            ID_CONV1:   return 64'(conv1);
            ID_CONC1:   return 64'(conc1);
            ID_HALT1:   return 64'(halt1);
            ID_ERR1:    return 64'(err1);
            ID_STALL3:  return 64'(stall3);
            ID_SEL3:    return 64'(sel3);
            ID_DFW3:    return 64'(dfw3);
            ID_FREEZE3: return 64'(freeze3);
            default:    return 64'hdead;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_v(input string tag, input int id, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.exp = v;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, obs(e.id), e.exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v1, input logic v3, input logic [4:0] rsb,
                         input logic [4:0] rsa, input logic [1:0] use_rs,
                         input logic [4:0] rd, input logic wen, input logic ld,
                         input logic ec);
        d_valid1   = v1;
        d_valid3   = v3;
        d_rs       = {rsb, rsa};
        d_use_rs   = use_rs;
        d_rd       = rd;
        d_wen      = wen;
        d_is_load  = ld;
        d_is_ecall = ec;
    endtask

    task automatic idle();
        set_d(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    task automatic send_ecall();
        set_d(1, 0, 0, 0, 2'b00, 0, 0, 0, 1);
        tick();
        idle();
        tick();
        tick();
    endtask

    initial begin
        // Reset with hostile inputs: every output must stay low
        set_d(1, 1, 5, 5, 2'b11, 6, 1, 1, 0);
        br_taken = 1; dm_busy = 1; con_ready = 1; reg_a0 = 0; reg_a1 = 0;
        expect_v("rst_stall",  ID_STALL1, 0);
        expect_v("rst_flush",  ID_FLUSH1, 0);
        expect_v("rst_freeze", ID_FREEZE1, 0);
        expect_v("rst_freeze3", ID_FREEZE3, 0);
        expect_v("rst_sel",    ID_SEL1, 0);
        expect_v("rst_wwen",   ID_WWEN1, 0);
        expect_v("rst_conv",   ID_CONV1, 0);
        expect_v("rst_halt",   ID_HALT1, 0);
        expect_v("rst_err",    ID_ERR1, 0);
        tick();
        rst = 1; br_taken = 0; dm_busy = 0; con_ready = 0;

        // Load-use: ld x5 ; add x6,x5,x5 on both latencies
        set_d(1, 1, 0, 0, 2'b00, 5, 1, 1, 0);
        expect_v("lu_pre1", ID_STALL1, 0);
        expect_v("lu_pre3", ID_STALL3, 0);
        tick();
        set_d(1, 1, 5, 5, 2'b11, 6, 1, 0, 0);
        expect_v("lu_c1_stall1", ID_STALL1, 1);
        expect_v("lu_c1_stall3", ID_STALL3, 1);
        expect_v("lu_c1_flush1", ID_FLUSH1, 0);
        tick();
        expect_v("lu_c2_stall1", ID_STALL1, 0);
        expect_v("lu_c2_stall3", ID_STALL3, 1);
        tick();
        d_valid1 = 0;
        expect_v("lu1_sel_w",  ID_SEL1, 4'b1010);
        expect_v("lu1_wwen",   ID_WWEN1, 1);
        expect_v("lu1_wrd",    ID_WRD1, 5);
        expect_v("lu_c3_stall3", ID_STALL3, 1);
        tick();
        expect_v("lu_c4_stall3", ID_STALL3, 0);
        expect_v("lu1_sel_off", ID_SEL1, 0);
        tick();
        d_valid3 = 0;
        d_rs = {5'd6, 5'd5};
        expect_v("lu3_sel_w", ID_SEL3, 6'b100100);
        expect_v("dfw3",      ID_DFW3, 2'b01);
        expect_v("dfw1",      ID_DFW1, 2'b10);
        expect_v("lu1_wwen2", ID_WWEN1, 1);
        expect_v("lu1_wrd2",  ID_WRD1, 6);
        tick();
        idle();
        repeat (4) tick();

        // Youngest producer wins; x0 never forwards
        set_d(1, 0, 0, 0, 2'b00, 1, 1, 0, 0);
        tick();
        tick();
        set_d(1, 0, 0, 1, 2'b01, 7, 1, 0, 0);
        expect_v("alu_nostall", ID_STALL1, 0);
        tick();
        set_d(1, 0, 0, 0, 2'b00, 0, 1, 0, 0);
        expect_v("fwd_young", ID_SEL1, 4'b0001);
        expect_v("fwd_wwen",  ID_WWEN1, 1);
        expect_v("fwd_wrd",   ID_WRD1, 1);
        tick();
        set_d(1, 0, 1, 0, 2'b11, 3, 0, 0, 0);
        tick();
        idle();
        expect_v("fwd_x0",    ID_SEL1, 0);
        expect_v("fwd_wrd7",  ID_WRD1, 7);
        tick();
        repeat (2) tick();

        // Branch flush beats load-use; E gets a bubble
        set_d(1, 0, 0, 0, 2'b00, 8, 1, 1, 0);
        tick();
        set_d(1, 0, 0, 8, 2'b01, 9, 1, 0, 0);
        br_taken = 1;
        expect_v("br_flush", ID_FLUSH1, 1);
        expect_v("br_stall", ID_STALL1, 0);
        tick();
        idle();
        br_taken = 0;
        tick();
        expect_v("br_ld_wwen", ID_WWEN1, 1);
        expect_v("br_ld_wrd",  ID_WRD1, 8);
        tick();
        expect_v("br_bubble_wwen", ID_WWEN1, 0);
        tick();

        // Memory back-pressure freezes the whole shadow pipeline
        set_d(1, 0, 0, 0, 2'b00, 10, 1, 0, 0);
        tick();
        set_d(1, 0, 0, 0, 2'b00, 11, 1, 0, 0);
        tick();
        set_d(1, 0, 0, 10, 2'b01, 12, 1, 0, 0);
        tick();
        idle();
        dm_busy = 1;
        br_taken = 1;
        for (int c = 0; c < 4; c++) begin
            expect_v("frz_freeze", ID_FREEZE1, 1);
            expect_v("frz_flush",  ID_FLUSH1, 0);
            expect_v("frz_wwen",   ID_WWEN1, 0);
            expect_v("frz_wrd",    ID_WRD1, 10);
            expect_v("frz_sel",    ID_SEL1, 4'b0010);
            tick();
        end
        dm_busy = 0;
        br_taken = 0;
        expect_v("unfrz_freeze", ID_FREEZE1, 0);
        expect_v("unfrz_wwen",   ID_WWEN1, 1);
        expect_v("unfrz_wrd",    ID_WRD1, 10);
        expect_v("unfrz_sel",    ID_SEL1, 4'b0010);
        tick();
        repeat (2) tick();

        // Console putchar with delayed acceptance
        reg_a0 = 1;
        reg_a1 = 64'h41;
        send_ecall();
        expect_v("con_trig_freeze", ID_FREEZE1, 0);
        expect_v("con_trig_conv",   ID_CONV1, 0);
        tick();
        reg_a1 = 64'h55;
        for (int c = 0; c < 3; c++) begin
            expect_v("con_valid",  ID_CONV1, 1);
            expect_v("con_char",   ID_CONC1, 8'h41);
            expect_v("con_freeze", ID_FREEZE1, 1);
            tick();
        end
        con_ready = 1;
        expect_v("con_hs_valid",  ID_CONV1, 1);
        expect_v("con_hs_freeze", ID_FREEZE1, 1);
        tick();
        con_ready = 0;
        expect_v("con_done_valid",  ID_CONV1, 0);
        expect_v("con_done_freeze", ID_FREEZE1, 0);
        tick();

        // Halt, then async reset clears it
        reg_a0 = 0;
        send_ecall();
        expect_v("halt_trig", ID_HALT1, 0);
        tick();
        for (int c = 0; c < 2; c++) begin
            expect_v("halt_flag",   ID_HALT1, 1);
            expect_v("halt_freeze", ID_FREEZE1, 1);
            expect_v("halt_err",    ID_ERR1, 0);
            tick();
        end
        #2 rst = 0;
        #1;
        expect_v("halt_rst_halt",   ID_HALT1, 0);
        expect_v("halt_rst_freeze", ID_FREEZE1, 0);
        drain();
        #2 rst = 1;
        @(posedge clk);
        #1;

        // Unsupported service
        reg_a0 = 7;
        send_ecall();
        expect_v("err_trig", ID_HALT1, 0);
        tick();
        expect_v("err_halt",   ID_HALT1, 1);
        expect_v("err_flag",   ID_ERR1, 1);
        expect_v("err_freeze", ID_FREEZE1, 1);
        tick();
        #2 rst = 0;
        #1;
        expect_v("err_rst_halt", ID_HALT1, 0);
        expect_v("err_rst_err",  ID_ERR1, 0);
        drain();
        #2 rst = 1;
        @(posedge clk);
        #1;
        expect_v("post_rst_freeze", ID_FREEZE1, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
